universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised N-bit universal shift register: hold, shift right, shift left and parallel load.
//  Serial in/out is available at both ends, with full parallel output.
//  Adds an autonomous burst serializer: load a word, then shift it a programmed number of
//  places without per-cycle control, reporting busy/done.
//  Used as the common serialize/deserialize stage for the sequential-circuit library.
// PARAMETERS
//  N          8     register width in bits; N >= 2
//  RESET_VAL  0     value of q after reset; N bits wide
//  (local) CW = $clog2(N)+1   width of len and of the internal shift counter
// PORTS
//  clk        in   1    single clock; all state updates on posedge
//  rst        in   1    asynchronous, active-high reset
//  mode       in   2    manual op when idle: 00 hold, 01 shift right, 10 shift left, 11 load
//  ser_in_r   in   1    bit entering q[N-1] on a right shift
//  ser_in_l   in   1    bit entering q[0] on a left shift
//  par_in     in   N    parallel load data (mode 11 or start)
//  start      in   1    begin burst; sampled only when busy=0
//  dir        in   1    burst direction, sampled with start: 0 right, 1 left
//  len        in   CW   burst shift count, sampled with start
//  q          out  N    register contents (registered)
//  ser_out_r  out  1    q[0]
//  ser_out_l  out  1    q[N-1]
//  busy       out  1    1 while a burst is shifting
//  done       out  1    one-cycle pulse after the last burst shift
// BEHAVIOUR
//  Reset (async, immediate): q=RESET_VAL, busy=0, done=0, state IDLE, cnt=0.
//  State machine has two states, IDLE and BURST.
//  IDLE, start=0: mode executes every clock.
//    01: q <= {ser_in_r, q[N-1:1]}
//    10: q <= {q[N-2:0], ser_in_l}
//    11: q <= par_in
//    00: q holds
//  IDLE, start=1 (has priority over mode): at edge T, q <= par_in and dir is latched.
//    eff_len = (len==0 || len>N) ? N : len; cnt <= eff_len; state <= BURST; busy=1 from T+1.
//  BURST: each clock shifts one place in the latched dir, using ser_in_r/ser_in_l as fill.
//    cnt decrements each shift. On the shift taken with cnt==1: state <= IDLE, busy <= 0, done <= 1.
//    Latency: done is high in cycle T+1+eff_len for exactly one cycle.
//  Serial output timing (right burst): at T+1+k, ser_out_r = par_in[k], for k = 0..eff_len-1.
//  Left burst mirrors this on ser_out_l = par_in[N-1-k].
//  While busy: mode, start, dir and len are ignored; par_in is not sampled.
//  start on the cycle done is high is accepted; back-to-back bursts leave no idle gap.
//  Reset mid-burst aborts immediately: no done pulse, q=RESET_VAL.
//  done is 0 on every cycle except the single completion cycle.
//  busy and done are never high together.
// STRUCTURE
//  Package shift_reg_pkg holds:
//    MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
//    DIR_R=1'b0, DIR_L=1'b1
//    state encoding ST_IDLE, ST_BURST
//  Sub-module shift_burst_ctrl: FSM, cnt, len saturation, busy/done.
//    Outputs per-cycle op {load, shr, shl} to the datapath.
//  Top level contains the N-bit datapath mux, the q register and the output assigns.
// TESTING
//  1. Reset
//     Stimulus: N=8, RESET_VAL=8'hA5; assert rst mid-cycle.
//     Required: q=8'hA5 immediately (async); busy=0, done=0.
//  2. Manual modes
//     Stimulus: load 8'h96, then 3 cycles of mode 01 with ser_in_r=1.
//     Required: q goes 96 -> CB -> E5 -> F2.
//     Stimulus: then mode 10 with ser_in_l=0.
//     Required: q=E4.
//  3. Right burst
//     Stimulus: start, dir=0, len=8, par_in=8'hB4, ser_in_r=0.
//     Required: ser_out_r over 8 cycles is 0,0,1,0,1,1,0,1.
//     Required: busy high 8 cycles; done pulses once; final q=8'h00.
//  4. len edge cases
//     Stimulus: len=0 and, separately, len=12.
//     Required: both run 8 shifts.
//     Stimulus: len=1, dir=1, par_in=8'h81, ser_in_l=1.
//     Required: done at T+2; q=8'h03.
//  5. Ignored inputs and back-to-back bursts
//     Stimulus: start pulses and mode=11 while busy.
//     Required: no effect on q or cnt.
//     Stimulus: start asserted in the done cycle.
//     Required: new burst loads with no gap.
//  6. Reset mid-burst
//     Stimulus: assert rst at shift 3 of 8.
//     Required: q=RESET_VAL, busy=0; no done pulse ever appears.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: manual modes, burst direction,
// controller states and the per-cycle datapath op.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic load;
    logic shr;
    logic shl;
  } op_t;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle of the universal shift register; slave is the register side,
// master is whoever drives modes, bursts and parallel data.
interface universal_shift_reg_if #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
);
  logic [1:0]    mode;
  logic          ser_in_r;
  logic          ser_in_l;
  logic [N-1:0]  par_in;
  logic          start;
  logic          dir;
  logic [CW-1:0] len;
  logic [N-1:0]  q;
  logic          ser_out_r;
  logic          ser_out_l;
  logic          busy;
  logic          done;

  modport slave (
    input  mode, ser_in_r, ser_in_l, par_in, start, dir, len,
    output q, ser_out_r, ser_out_l, busy, done
  );

  modport master (
    output mode, ser_in_r, ser_in_l, par_in, start, dir, len,
    input  q, ser_out_r, ser_out_l, busy, done
  );
endinterface

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: arbitrates manual modes against start, runs the shift counter and
// produces the per-cycle datapath op plus busy/done.
//
//   state    | meaning
//   ST_IDLE  | manual mode executes each clock; start loads par_in and arms a burst
//   ST_BURST | one shift per clock in the latched direction until cnt reaches zero
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic          dir,
  input  logic [CW-1:0] len,
  output op_t           op,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] N_CW = CW'(N);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic [CW-1:0] eff_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Zero or over-range lengths mean a full-width burst.
  assign eff_len = ((len == '0) || (len > N_CW)) ? N_CW : len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    op      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op.load = 1'b1;
          dir_d   = dir;
          cnt_d   = eff_len;
          state_d = ST_BURST;
        end else begin
          unique case (mode)
            MODE_HOLD: ;
            MODE_SHR:  op.shr  = 1'b1;
            MODE_SHL:  op.shl  = 1'b1;
            MODE_LOAD: op.load = 1'b1;
          endcase
        end
      end
      ST_BURST: begin
        unique case (dir_q)
          DIR_R: op.shr = 1'b1;
          DIR_L: op.shl = 1'b1;
        endcase
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign busy = (state_q == ST_BURST);
  assign done = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register with manual hold/shift/load and an autonomous
// burst serializer; the controller decides the op, this level owns the data.
module universal_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int           N         = 8,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  rst,
  universal_shift_reg_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  op_t          op;
  logic [N-1:0] q_q, q_d;

  shift_burst_ctrl #(
    .N  (N),
    .CW (CW)
  ) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .mode  (bus.mode),
    .start (bus.start),
    .dir   (bus.dir),
    .len   (bus.len),
    .op    (op),
    .busy  (bus.busy),
    .done  (bus.done)
  );

  always_comb begin
    q_d = q_q;
    if (op.load) begin
      q_d = bus.par_in;
    end else if (op.shr) begin
      q_d = {bus.ser_in_r, q_q[N-1:1]};
    end else if (op.shl) begin
      q_d = {q_q[N-2:0], bus.ser_in_l};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.ser_out_r = q_q[0];
  assign bus.ser_out_l = q_q[N-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed and random checks of universal_shift_reg against a word-level behavioural model.
module tb_universal_shift_reg;

  localparam int N = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  universal_shift_reg_if #(.N(N)) bus ();

  universal_shift_reg #(.N(N), .RESET_VAL(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [7:0] mq;
  bit         mbusy, mdone, mdir;
  int         mrem;

  logic sr_hist [0:31];
  logic sl_hist [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq = RV; mbusy = 0; mdone = 0; mrem = 0; mdir = 0;
  endtask

  task automatic model_update();
    if (mbusy) begin
      if (!mdir) mq = (mq >> 1) | (bus.ser_in_r ? 8'h80 : 8'h00);
      else       mq = (mq << 1) | (bus.ser_in_l ? 8'h01 : 8'h00);
      mrem  = mrem - 1;
      mdone = (mrem == 0);
      mbusy = (mrem != 0);
    end else begin
      mdone = 0;
      if (bus.start) begin
        mq    = bus.par_in;
        mdir  = bus.dir;
        mrem  = (bus.len == 0 || int'(bus.len) > N) ? N : int'(bus.len);
        mbusy = 1;
      end else begin
        case (bus.mode)
          2'd1: mq = (mq >> 1) | (bus.ser_in_r ? 8'h80 : 8'h00);
          2'd2: mq = (mq << 1) | (bus.ser_in_l ? 8'h01 : 8'h00);
          2'd3: mq = bus.par_in;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all();
    chk("q", bus.q, mq);
    chk("ser_out_r", bus.ser_out_r, mq[0]);
    chk("ser_out_l", bus.ser_out_l, mq[7]);
    chk("busy", bus.busy, mbusy);
    chk("done", bus.done, mdone);
    chk("busy_and_done", bus.busy & bus.done, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.mode = 2'b00; bus.start = 0; bus.dir = 0; bus.len = '0;
    bus.par_in = '0; bus.ser_in_r = 0; bus.ser_in_l = 0;
  endtask

  task automatic mid_cycle_reset();
    #2 rst = 1;
    #1;
    chk("rst_q", bus.q, 8'hA5);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    model_reset();
    #1 rst = 0;
  endtask

  task automatic burst(input logic [7:0] par, input logic d, input logic [3:0] l,
                       input logic fr, input logic fl, input bit noise,
                       output int busy_cnt, output int done_cnt, output int done_at,
                       output logic [7:0] q0);
    bus.mode = 2'b00; bus.start = 1; bus.dir = d; bus.len = l;
    bus.par_in = par; bus.ser_in_r = fr; bus.ser_in_l = fl;
    step();
    q0 = bus.q;
    sr_hist[0] = bus.ser_out_r;
    sl_hist[0] = bus.ser_out_l;
    busy_cnt = int'(bus.busy);
    done_cnt = 0;
    done_at  = -1;
    bus.start = 0;
    for (int j = 1; j <= 20; j++) begin
      if (noise) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.mode   = 2'b11;
        bus.par_in = 8'($urandom);
        bus.dir    = 1'($urandom);
        bus.len    = 4'($urandom);
      end
      step();
      sr_hist[j] = bus.ser_out_r;
      sl_hist[j] = bus.ser_out_l;
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        done_cnt++;
        done_at = j;
        break;
      end
    end
    bus.start = 0;
    bus.mode  = 2'b00;
  endtask

  int bc, dc, da;
  logic [7:0] q0, exp_bits;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    model_reset();
    #2 rst = 1;
    #1;
    chk("por_q", bus.q, 8'hA5);
    chk("por_busy", bus.busy, 0);
    chk("por_done", bus.done, 0);
    #19 rst = 0;

    // reset asserted mid-cycle after a load
    bus.mode = 2'b11; bus.par_in = 8'h3C;
    step();
    bus.mode = 2'b00;
    mid_cycle_reset();
    step();

    // manual modes
    bus.mode = 2'b11; bus.par_in = 8'h96;
    step(); chk("load_96", bus.q, 8'h96);
    bus.mode = 2'b01; bus.ser_in_r = 1;
    step(); chk("shr1", bus.q, 8'hCB);
    step(); chk("shr2", bus.q, 8'hE5);
    step(); chk("shr3", bus.q, 8'hF2);
    bus.mode = 2'b10; bus.ser_in_l = 0;
    step(); chk("shl1", bus.q, 8'hE4);
    idle_inputs();
    step(); chk("hold", bus.q, 8'hE4);

    // right burst of B4
    burst(8'hB4, 0, 4'd8, 0, 0, 0, bc, dc, da, q0);
    exp_bits = 8'hB4;
    for (int k = 0; k < 8; k++) chk("burst_r_bit", sr_hist[k], exp_bits[k]);
    chk("burst_r_busy_cycles", bc, 8);
    chk("burst_r_done_cnt", dc, 1);
    chk("burst_r_done_at", da, 8);
    chk("burst_r_final_q", bus.q, 8'h00);
    step(); chk("done_one_cycle", bus.done, 0);

    // len saturation
    burst(8'h5C, 0, 4'd0, 1, 0, 0, bc, dc, da, q0);
    chk("len0_busy", bc, 8); chk("len0_done_at", da, 8);
    burst(8'h3E, 1, 4'd12, 0, 1, 0, bc, dc, da, q0);
    chk("len12_busy", bc, 8); chk("len12_done_at", da, 8);
    chk("len12_q", bus.q, 8'hFF);

    // single-shift left burst
    burst(8'h81, 1, 4'd1, 0, 1, 0, bc, dc, da, q0);
    chk("len1_first_l", sl_hist[0], 1);
    chk("len1_done_at", da, 1);
    chk("len1_q", bus.q, 8'h03);

    // ignored inputs while busy
    burst(8'h5A, 0, 4'd5, 1, 0, 1, bc, dc, da, q0);
    chk("noise_done_at", da, 5);
    chk("noise_busy", bc, 5);
    chk("noise_q", bus.q, 8'hFA);

    // back-to-back: second start lands on the done cycle
    burst(8'hC3, 1, 4'd3, 0, 0, 0, bc, dc, da, q0);
    chk("b2b_a_done_at", da, 3);
    burst(8'h69, 0, 4'd2, 0, 0, 0, bc, dc, da, q0);
    chk("b2b_b_loaded", q0, 8'h69);
    chk("b2b_b_done_at", da, 2);
    chk("b2b_b_q", bus.q, 8'h1A);

    // reset mid-burst
    bus.start = 1; bus.dir = 0; bus.len = 4'd8; bus.par_in = 8'hE7;
    step();
    bus.start = 0;
    step(); step(); step();
    mid_cycle_reset();
    dc = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      dc += int'(bus.done);
    end
    chk("abort_no_done", dc, 0);
    chk("abort_q", bus.q, 8'hA5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.mode     = 2'($urandom);
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.dir      = 1'($urandom);
      bus.len      = 4'($urandom_range(0, 15));
      bus.par_in   = 8'($urandom);
      bus.ser_in_r = 1'($urandom);
      bus.ser_in_l = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
